// File: rtl/systolic_skew_feeder_if.sv
// Handshake and array-facing bus between the on-chip buffers, the skew feeder
// and the systolic array.
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 8,
  parameter int ROW   = 2,
  parameter int COL   = 2,
  parameter int DEPTH = 16
);
  localparam int KW = $clog2(DEPTH + 1);

  logic                       start_in;
  logic [KW-1:0]              k_len_in;
  logic                       wt_valid_in;
  logic                       wt_ready_out;
  logic [COL-1:0][WIDTH-1:0]  wt_data_in;
  logic                       feat_valid_in;
  logic                       feat_ready_out;
  logic [ROW-1:0][WIDTH-1:0]  feat_data_in;
  logic [COL-1:0][WIDTH-1:0]  weight_out;
  logic [ROW-1:0][WIDTH-1:0]  feature_out;
  logic                       ctrl_out;
  logic                       busy_out;
  logic                       done_out;

  modport master (
    output start_in, k_len_in, wt_valid_in, wt_data_in, feat_valid_in, feat_data_in,
    input  wt_ready_out, feat_ready_out, weight_out, feature_out, ctrl_out, busy_out, done_out
  );

  modport slave (
    input  start_in, k_len_in, wt_valid_in, wt_data_in, feat_valid_in, feat_data_in,
    output wt_ready_out, feat_ready_out, weight_out, feature_out, ctrl_out, busy_out, done_out
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds one weight vector and a skewed tile of K feature vectors into the
// systolic array, sequencing load-weights -> stream -> drain per tile.
module systolic_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int ROW   = 2,
  parameter int COL   = 2,
  parameter int DEPTH = 16
) (
  input  logic                  clk_in3,
  input  logic                  nrst_in3,
  systolic_skew_feeder_if.slave bus
);
  localparam int KW        = $clog2(DEPTH + 1);
  localparam int DRAIN_LEN = ROW - 1 + COL;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  localparam logic [KW-1:0] DEPTH_K    = KW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t                    state_reg, state_next;
  logic [KW-1:0]             k_len_reg;
  logic [KW-1:0]             count_reg;
  logic [DW-1:0]             drain_cnt_reg;
  logic [COL-1:0][WIDTH-1:0] weight_reg;
  logic                      ctrl_reg;
  logic [ROW-1:0][WIDTH-1:0] feature_vec;

  logic wt_ready, feat_ready, busy, done;
  logic start_ok, wt_fire, feat_fire;

  assign start_ok  = (state_reg == IDLE) && bus.start_in &&
                     (bus.k_len_in != '0) && (bus.k_len_in <= DEPTH_K);
  assign wt_fire   = wt_ready && bus.wt_valid_in;
  assign feat_fire = feat_ready && bus.feat_valid_in;

  always_ff @(posedge clk_in3) begin
    if (nrst_in3) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok)                      state_next = LOAD_W;
      LOAD_W:  if (wt_fire)                       state_next = STREAM;
      STREAM:  if (count_reg == k_len_reg)        state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == DRAIN_LAST)   state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  // done shares its cycle with the last DRAIN cycle, so a start seen alongside it is still ignored
  always_comb begin
    wt_ready   = (state_reg == LOAD_W);
    feat_ready = (state_reg == STREAM) && (count_reg < k_len_reg);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DRAIN) && (drain_cnt_reg == DRAIN_LAST);
  end

  always_ff @(posedge clk_in3) begin
    if (nrst_in3) begin
      k_len_reg     <= '0;
      count_reg     <= '0;
      drain_cnt_reg <= '0;
      weight_reg    <= '0;
      ctrl_reg      <= 1'b0;
    end else begin
      if (start_ok) begin
        k_len_reg <= bus.k_len_in;
        count_reg <= '0;
      end else if (feat_fire) begin
        count_reg <= count_reg + 1'b1;
      end
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : '0;
      ctrl_reg      <= wt_fire;
      if (wt_fire) weight_reg <= bus.wt_data_in;
    end
  end

  // Lane r is a chain of r+1 registers; idle cycles inject zeros so bubbles keep their slot.
  for (genvar gi = 0; gi < ROW; gi++) begin : g_lane
    logic [WIDTH-1:0] stage_reg [0:gi];

    always_ff @(posedge clk_in3) begin
      if (nrst_in3) begin
        for (int s = 0; s <= gi; s++) stage_reg[s] <= '0;
      end else begin
        stage_reg[0] <= feat_fire ? bus.feat_data_in[gi] : '0;
        for (int s = 1; s <= gi; s++) stage_reg[s] <= stage_reg[s-1];
      end
    end

    assign feature_vec[gi] = stage_reg[gi];
  end

  assign bus.wt_ready_out   = wt_ready;
  assign bus.feat_ready_out = feat_ready;
  assign bus.busy_out       = busy;
  assign bus.done_out       = done;
  assign bus.ctrl_out       = ctrl_reg;
  assign bus.weight_out     = weight_reg;
  assign bus.feature_out    = feature_vec;
endmodule
